dot_mac_seq: RTL and testbench

Sequencer for the saturating fixed-point multiply-accumulate datapath. It computes a bit-exact dot product. It reads x[i] and y[i] pairs from two synchronous sample memories and issues one L_mac operation per term. Each term's saturated 32-bit result feeds back as the next term's accumulator, so the saturation order matches the sequential C reference. Upper-level DSP routines (autocorrelation, filter energy, cross-correlation) use it as a shared dot-product engine.

---
 rtl/dot_mac_seq_pkg.sv | 23 ++
 rtl/dot_mac_seq_l_mac.sv | 63 ++++++
 rtl/dot_mac_seq.sv | 184 ++++++++++++++++++
 tb/tb_dot_mac_seq.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/dot_mac_seq_pkg.sv
// Shared definitions for the dot-product sequencer and its L_mac datapath.
package dot_mac_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    ISSUE   = 3'd2,
    WAIT    = 3'd3,
    CAPTURE = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam int unsigned LAT_DEFAULT = 4;

  localparam logic [31:0] MAX_32 = 32'h7FFF_FFFF;
  localparam logic [31:0] MIN_32 = 32'h8000_0000;

  // True when a 32-bit accumulator sits on either saturation rail.
  function automatic logic is_rail(input logic [31:0] v);
    return (v == MAX_32) || (v == MIN_32);
  endfunction

endpackage

// File: rtl/dot_mac_seq_l_mac.sv
// Pipelined saturating L_mac: out = L_add(c, L_mult(a, b)), DEPTH cycles from a/b/c to out.
// DEPTH must be at least 2 (input register plus at least one output stage).
module dot_mac_seq_l_mac
  import dot_mac_seq_pkg::*;
#(
  parameter int unsigned DEPTH = LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [31:0] c,
  output logic [31:0] out
);

  logic [15:0]        a_q;
  logic [15:0]        b_q;
  logic [31:0]        c_q;
  logic signed [31:0] prod;
  logic               mult_ovf;
  logic [31:0]        mult;
  logic [32:0]        sum;
  logic               add_ovf;
  logic [31:0]        mac;
  logic [31:0]        pipe [DEPTH-1];

  // L_mult (doubling with the single -32768*-32768 overflow) followed by saturating L_add.
  always_comb begin
    prod     = $signed({{16{a_q[15]}}, a_q}) * $signed({{16{b_q[15]}}, b_q});
    mult_ovf = (prod == 32'sh4000_0000);
    mult     = mult_ovf ? MAX_32 : {prod[30:0], 1'b0};
    sum      = {c_q[31], c_q} + {mult[31], mult};
    add_ovf  = sum[32] ^ sum[31];
    if (add_ovf) begin
      mac = sum[32] ? MIN_32 : MAX_32;
    end else begin
      mac = sum[31:0];
    end
  end

  // Input register, then DEPTH-1 stages delivering the result.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      for (int i = 0; i < int'(DEPTH) - 1; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      a_q     <= a;
      b_q     <= b;
      c_q     <= c;
      pipe[0] <= mac;
      for (int i = 1; i < int'(DEPTH) - 1; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign out = pipe[DEPTH-2];

endmodule

// File: rtl/dot_mac_seq.sv
// Dot-product sequencer: one L_mac per term, each saturated result fed back as the next accumulator.
module dot_mac_seq
  import dot_mac_seq_pkg::*;
#(
  parameter int unsigned AW  = 10,
  parameter int unsigned LW  = 8,
  parameter int unsigned LAT = LAT_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [LW-1:0] len,
  input  logic [AW-1:0] x_base,
  input  logic [AW-1:0] y_base,
  input  logic [31:0]   acc_init,
  output logic          rd_en,
  output logic [AW-1:0] x_addr,
  output logic [AW-1:0] y_addr,
  input  logic [15:0]   x_data,
  input  logic [15:0]   y_data,
  output logic          busy,
  output logic          done,
  output logic [31:0]   result,
  output logic          sat
);

  localparam int unsigned CW = (LAT > 2) ? $clog2(LAT - 1) : 1;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [LW-1:0] k, k_d;
  logic [LW-1:0] n, n_d;
  logic [AW-1:0] xb, xb_d;
  logic [AW-1:0] yb, yb_d;
  logic [31:0]   acc, acc_d;
  logic [31:0]   result_d;
  logic          sat_d;
  logic          rd_en_d;
  logic [AW-1:0] x_addr_d, y_addr_d;
  logic          busy_d;
  logic          done_d;
  logic          more_terms;
  logic [15:0]   mac_a, mac_b;
  logic [31:0]   mac_c;
  logic [31:0]   mac_out;

  dot_mac_seq_l_mac #(
    .DEPTH (LAT)
  ) u_l_mac (
    .clk   (clk),
    .reset (reset),
    .a     (mac_a),
    .b     (mac_b),
    .c     (mac_c),
    .out   (mac_out)
  );

  assign more_terms = ((LW+1)'(k) + (LW+1)'(1)) < (LW+1)'(n);

  // Next-state and next-output logic; registered outputs are prepared one cycle ahead.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    k_d      = k;
    n_d      = n;
    xb_d     = xb;
    yb_d     = yb;
    acc_d    = acc;
    result_d = result;
    sat_d    = sat;
    rd_en_d  = 1'b0;
    x_addr_d = x_addr;
    y_addr_d = y_addr;
    busy_d   = busy;
    done_d   = 1'b0;
    mac_a    = '0;
    mac_b    = '0;
    mac_c    = '0;

    unique case (state)
      IDLE: begin
        if (start) begin
          sat_d  = 1'b0;
          busy_d = 1'b1;
          if (len != '0) begin
            n_d      = len;
            xb_d     = x_base;
            yb_d     = y_base;
            acc_d    = acc_init;
            k_d      = '0;
            rd_en_d  = 1'b1;
            x_addr_d = x_base;
            y_addr_d = y_base;
            state_d  = FETCH;
          end else begin
            result_d = acc_init;
            done_d   = 1'b1;
            state_d  = DONE;
          end
        end
      end
      FETCH: begin
        state_d = ISSUE;
      end
      ISSUE: begin
        mac_a   = x_data;
        mac_b   = y_data;
        mac_c   = acc;
        cnt_d   = CW'(LAT - 2);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt == '0) begin
          state_d = CAPTURE;
          // Read for the next term lands in the CAPTURE cycle so data is ready at ISSUE.
          if (more_terms) begin
            rd_en_d  = 1'b1;
            x_addr_d = xb + AW'(k) + AW'(1);
            y_addr_d = yb + AW'(k) + AW'(1);
          end
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      CAPTURE: begin
        acc_d = mac_out;
        if (is_rail(mac_out)) begin
          sat_d = 1'b1;
        end
        if (more_terms) begin
          k_d     = k + LW'(1);
          state_d = ISSUE;
        end else begin
          result_d = mac_out;
          done_d   = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      k      <= '0;
      n      <= '0;
      xb     <= '0;
      yb     <= '0;
      acc    <= '0;
      result <= '0;
      sat    <= 1'b0;
      rd_en  <= 1'b0;
      x_addr <= '0;
      y_addr <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      k      <= k_d;
      n      <= n_d;
      xb     <= xb_d;
      yb     <= yb_d;
      acc    <= acc_d;
      result <= result_d;
      sat    <= sat_d;
      rd_en  <= rd_en_d;
      x_addr <= x_addr_d;
      y_addr <= y_addr_d;
      busy   <= busy_d;
      done   <= done_d;
    end
  end

endmodule

// File: tb/tb_dot_mac_seq.sv
// Directed self-checking bench for dot_mac_seq with two synchronous sample memories.
module tb_dot_mac_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  len;
  logic [9:0]  x_base;
  logic [9:0]  y_base;
  logic [31:0] acc_init;
  logic        rd_en;
  logic [9:0]  x_addr;
  logic [9:0]  y_addr;
  logic [15:0] x_data;
  logic [15:0] y_data;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        sat;

  logic [15:0] xmem [1024];
  logic [15:0] ymem [1024];
  logic [9:0]  xq [$];
  logic [9:0]  yq [$];

  int n_checks;
  int n_fail;

  dot_mac_seq dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .len      (len),
    .x_base   (x_base),
    .y_base   (y_base),
    .acc_init (acc_init),
    .rd_en    (rd_en),
    .x_addr   (x_addr),
    .y_addr   (y_addr),
    .x_data   (x_data),
    .y_data   (y_data),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .sat      (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous read memories: data valid the cycle after rd_en.
  always @(posedge clk) begin
    if (rd_en) begin
      x_data <= xmem[x_addr];
      y_data <= ymem[y_addr];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference L_mac computed with wide integers and explicit clamping.
  function automatic logic [31:0] ref_mac(input logic [31:0] acc, input logic [15:0] x,
                                          input logic [15:0] y);
    longint p;
    longint s;
    p = longint'($signed(x)) * longint'($signed(y)) * 2;
    if (p > 64'sh7FFF_FFFF) p = 64'sh7FFF_FFFF;
    s = longint'($signed(acc)) + p;
    if (s > 64'sh7FFF_FFFF) s = 64'sh7FFF_FFFF;
    if (s < -64'sh8000_0000) s = -64'sh8000_0000;
    return 32'(s);
  endfunction

  // One transaction: start, watch cycle by cycle, check latency, result, sat and reads.
  task automatic run_op(input string tag, input logic [7:0] n, input logic [9:0] xb,
                        input logic [9:0] yb, input logic [31:0] ai, input logic [31:0] exp_res,
                        input logic exp_sat, input int exp_lat, input int glitch_t);
    int lat;
    int rd_cnt;
    int rd_first;
    lat = 0;
    rd_cnt = 0;
    rd_first = 0;
    xq.delete();
    yq.delete();
    @(negedge clk);
    start    = 1'b1;
    len      = n;
    x_base   = xb;
    y_base   = yb;
    acc_init = ai;
    for (int t = 1; t <= 100; t++) begin
      @(negedge clk);
      start = (glitch_t != 0) && (t == glitch_t);
      if (t == 1) check({tag, "_busy_first"}, 32'(busy), 32'd1);
      if (rd_en) begin
        rd_cnt++;
        if (rd_first == 0) rd_first = t;
        xq.push_back(x_addr);
        yq.push_back(y_addr);
      end
      if (done) begin
        lat = t;
        check({tag, "_busy_at_done"}, 32'(busy), 32'd1);
        check({tag, "_result"}, result, exp_res);
        check({tag, "_sat"}, 32'(sat), 32'(exp_sat));
        break;
      end
    end
    start = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_reads"}, 32'(rd_cnt), 32'(n));
    if (n != 0) check({tag, "_first_read"}, 32'(rd_first), 32'd1);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [31:0] gold;
    logic [9:0]  ad;
    int          done_seen;

    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    start    = 1'b0;
    len      = '0;
    x_base   = '0;
    y_base   = '0;
    acc_init = '0;
    x_data   = '0;
    y_data   = '0;
    for (int i = 0; i < 1024; i++) begin
      xmem[i] = '0;
      ymem[i] = '0;
    end
    xmem[10'h010] = 16'h4000; ymem[10'h020] = 16'h4000;
    for (int i = 0; i < 4; i++) begin
      xmem[10'h100 + i] = 16'h7FFF;
      ymem[10'h200 + i] = 16'h7FFF;
    end
    xmem[10'h110] = 16'h8000; ymem[10'h210] = 16'h8000;
    xmem[10'h120] = 16'h8000; ymem[10'h220] = 16'h7FFF;
    xmem[10'h3FE] = 16'd3;    ymem[10'h000] = 16'd10;
    xmem[10'h3FF] = 16'hFFFE; ymem[10'h001] = 16'd20;
    xmem[10'h000] = 16'd5;    ymem[10'h002] = 16'hFFFC;
    xmem[10'h001] = 16'd7;    ymem[10'h003] = 16'd1;

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_x_addr", 32'(x_addr), 32'd0);
    check("rst_y_addr", 32'(y_addr), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_sat", 32'(sat), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op("n0", 8'd0, 10'h000, 10'h000, 32'h1234_5678, 32'h1234_5678, 1'b0, 1, 0);
    run_op("n1_half", 8'd1, 10'h010, 10'h020, 32'h0, 32'h2000_0000, 1'b0, 7, 0);
    run_op("n4_sat", 8'd4, 10'h100, 10'h200, 32'h0, 32'h7FFF_FFFF, 1'b1, 22, 0);
    run_op("mult_sat", 8'd1, 10'h110, 10'h210, 32'h0, 32'h7FFF_FFFF, 1'b1, 7, 0);
    run_op("neg_sat", 8'd1, 10'h120, 10'h220, 32'h8000_0000, 32'h8000_0000, 1'b1, 7, 0);

    // Address wrap: hand-computed 100 + 60 - 80 - 40 + 14 = 54.
    gold = 32'd100;
    for (int i = 0; i < 4; i++) begin
      ad   = 10'h3FE + 10'(i);
      gold = ref_mac(gold, xmem[ad], ymem[i]);
    end
    check("wrap_gold_model", gold, 32'd54);
    run_op("wrap", 8'd4, 10'h3FE, 10'h000, 32'd100, 32'd54, 1'b0, 22, 0);
    check("wrap_naddr", 32'(xq.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      ad = 10'h3FE + 10'(i);
      check($sformatf("wrap_xaddr%0d", i), 32'(xq[i]), 32'(ad));
      check($sformatf("wrap_yaddr%0d", i), 32'(yq[i]), 32'(i));
    end

    // Start pulsed while busy: ignored, timing unchanged, not queued.
    run_op("glitch", 8'd1, 10'h010, 10'h020, 32'h0, 32'h2000_0000, 1'b0, 7, 3);
    done_seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (done || busy) done_seen = 1;
    end
    check("glitch_not_queued", 32'(done_seen), 32'd0);

    // Reset mid-operation aborts with no done pulse.
    @(negedge clk);
    start    = 1'b1;
    len      = 8'd4;
    x_base   = 10'h100;
    y_base   = 10'h200;
    acc_init = 32'h0;
    for (int t = 1; t <= 5; t++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_rd_en", 32'(rd_en), 32'd0);
    check("abort_result", result, 32'd0);
    reset = 1'b0;
    done_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) done_seen = 1;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    run_op("after_abort", 8'd4, 10'h3FE, 10'h000, 32'd100, 32'd54, 1'b0, 22, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
